// File: rtl/ad7606_ctrl_if.sv
// ADC pin bundle plus the sample stream toward the acquisition FIFO.
interface ad7606_ctrl_if;
    logic        adc_reset_o;
    logic        convst_o;
    logic        cs_o;
    logic        rd_o;
    logic        busy_i;
    logic        frstdata_i;
    logic [15:0] db_i;
    logic [15:0] sample_o;
    logic [2:0]  chan_o;
    logic        valid_o;
    logic        ready_i;

    modport master (
        output adc_reset_o, convst_o, cs_o, rd_o, sample_o, chan_o, valid_o,
        input  busy_i, frstdata_i, db_i, ready_i
    );

    modport slave (
        input  adc_reset_o, convst_o, cs_o, rd_o, sample_o, chan_o, valid_o,
        output busy_i, frstdata_i, db_i, ready_i
    );
endinterface

// File: rtl/ad7606_ctrl.sv
// AD7606 controller: reset, CONVST, BUSY wait, CS/RD word reads with
// FRSTDATA alignment check, and a valid/ready sample stream.
module ad7606_ctrl #(
    parameter int NCHAN   = 8,
    parameter int CONV_LO = 2,
    parameter int RD_LO   = 3,
    parameter int RD_HI   = 2,
    parameter int BUSY_TO = 500,
    parameter int RST_CYC = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    ad7606_ctrl_if.master     bus,
    output logic              active_o,
    output logic              done_o,
    output logic [1:0]        err_o
);

    localparam int M0      = (BUSY_TO > RST_CYC) ? BUSY_TO : RST_CYC;
    localparam int M1      = (M0 > CONV_LO) ? M0 : CONV_LO;
    localparam int M2      = (M1 > RD_LO) ? M1 : RD_LO;
    localparam int CNT_MAX = (M2 > RD_HI) ? M2 : RD_HI;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_LO - 1);
    localparam logic [CW-1:0] RDL_LAST  = CW'(RD_LO - 1);
    localparam logic [CW-1:0] RDH_LAST  = CW'(RD_HI - 1);
    localparam logic [CW-1:0] BUSY_LIM  = CW'(BUSY_TO);
    localparam logic [2:0]    LAST_CH   = 3'(NCHAN - 1);

    typedef enum logic [2:0] {
        ADC_RST, IDLE, CONV, WAIT_BUSY_HI, WAIT_BUSY_LO, RD_L, RD_H, LAST
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     ch_q, ch_d;
    logic [15:0]    hold_q, hold_d;
    logic [15:0]    sample_q, sample_d;
    logic [2:0]     chan_q, chan_d;
    logic           valid_q, valid_d;
    logic [1:0]     err_q, err_d;
    logic           busy_m, busy_s;
    logic           accept;

    assign accept       = valid_q & bus.ready_i;
    assign bus.sample_o = sample_q;
    assign bus.chan_o   = chan_q;
    assign bus.valid_o  = valid_q;
    assign err_o        = err_q;

    // Two-flop synchroniser for the asynchronous BUSY pin.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_m <= 1'b0;
            busy_s <= 1'b0;
        end else begin
            busy_m <= bus.busy_i;
            busy_s <= busy_m;
        end
    end

    // State, counters, hold register and output slot.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ADC_RST;
            cnt_q    <= '0;
            ch_q     <= '0;
            hold_q   <= '0;
            sample_q <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            hold_q   <= hold_d;
            sample_q <= sample_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Next-state, datapath updates and pin decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        hold_d   = hold_q;
        sample_d = sample_q;
        chan_d   = chan_q;
        valid_d  = valid_q & ~accept;
        err_d    = err_q;
        done_o   = 1'b0;

        bus.adc_reset_o = (state_q == ADC_RST);
        bus.convst_o    = (state_q != CONV);
        bus.cs_o        = !((state_q == RD_L) || (state_q == RD_H));
        bus.rd_o        = (state_q != RD_L);
        active_o        = (state_q != IDLE);

        unique case (state_q)
            ADC_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            IDLE: begin
                if (start_i) begin
                    state_d = CONV;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = WAIT_BUSY_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_BUSY_HI, WAIT_BUSY_LO: begin
                // One counter spans both wait states; it never exceeds BUSY_LIM.
                if (cnt_q >= BUSY_LIM) begin
                    err_d[0] = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (state_q == WAIT_BUSY_HI) begin
                    cnt_d = cnt_q + CW'(1);
                    if (busy_s) state_d = WAIT_BUSY_LO;
                end else if (!busy_s) begin
                    state_d = RD_L;
                    cnt_d   = '0;
                    ch_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_L: begin
                if (cnt_q == RDL_LAST) begin
                    hold_d = bus.db_i;
                    if ((ch_q == 3'd0) && !bus.frstdata_i) err_d[1] = 1'b1;
                    if ((ch_q != 3'd0) &&  bus.frstdata_i) err_d[1] = 1'b1;
                    state_d = RD_H;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_H: begin
                // Counter parks on RDH_LAST while the output slot is blocked.
                if (cnt_q != RDH_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!valid_q || accept) begin
                    sample_d = hold_q;
                    chan_d   = ch_q;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    if (ch_q == LAST_CH) begin
                        state_d = LAST;
                    end else begin
                        ch_d    = ch_q + 3'd1;
                        state_d = RD_L;
                    end
                end
            end
            LAST: begin
                if (!valid_q || accept) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = ADC_RST;
        endcase
    end

endmodule

// File: tb/tb_ad7606_ctrl.sv
// Scoreboard bench for ad7606_ctrl with a cycle-level AD7606 model.
`timescale 1ns/1ps
module tb_ad7606_ctrl;
    localparam int NCHAN    = 8;
    localparam int CONV_LO  = 2;
    localparam int RD_LO    = 3;
    localparam int RD_HI    = 2;
    localparam int BUSY_TO  = 50;
    localparam int RST_CYC  = 5;
    localparam int BUSY_CYC = 40;   // 4 us at 10 MHz

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       active_o;
    logic       done_o;
    logic [1:0] err_o;

    ad7606_ctrl_if bus();

    ad7606_ctrl #(
        .NCHAN(NCHAN), .CONV_LO(CONV_LO), .RD_LO(RD_LO), .RD_HI(RD_HI),
        .BUSY_TO(BUSY_TO), .RST_CYC(RST_CYC)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .bus(bus),
        .active_o(active_o), .done_o(done_o), .err_o(err_o)
    );

    always #50 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [18:0] exp_q[$];

    // model controls
    logic        busy_en    = 1'b1;
    logic        frst_fault = 1'b0;
    logic [15:0] data_base  = '0;

    // monitor counters
    int hs_cnt = 0, done_cnt = 0, valid_seen = 0;
    int conv_falls = 0, conv_bad = 0, rd_falls = 0, rd_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] base);
        for (int i = 0; i < NCHAN; i++) begin
            logic [2:0]  c;
            logic [15:0] s;
            c = 3'(i);
            s = base + 16'(i + 1);
            exp_q.push_back({c, s});
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (active_o && n < budget) begin
            tick();
            n++;
        end
        check("reach_idle", int'(active_o), 0);
    endtask

    // AD7606 model: BUSY after CONVST rise, next word on each RD fall.
    initial begin
        int busy_cnt = 0;
        int widx = 0;
        logic conv_q = 1'b1, rd_q = 1'b1;
        bus.busy_i = 1'b0;
        bus.db_i = '0;
        bus.frstdata_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!conv_q && bus.convst_o) begin
                widx = 0;
                if (busy_en) begin
                    busy_cnt = BUSY_CYC;
                    bus.busy_i = 1'b1;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) bus.busy_i = 1'b0;
            end
            if (rd_q && !bus.rd_o && !bus.cs_o) begin
                bus.db_i = data_base + 16'(widx + 1);
                bus.frstdata_i = (widx == 0) && !frst_fault;
                widx++;
            end
            conv_q = bus.convst_o;
            rd_q = bus.rd_o;
        end
    end

    // Monitor: scoreboard compare on each handshake, plus pin statistics.
    initial begin
        int conv_run = 0, rd_run = 0;
        logic conv_p = 1'b1, rd_p = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (bus.valid_o) valid_seen++;
                if (bus.valid_o && bus.ready_i) begin
                    hs_cnt++;
                    check("sb_nonempty", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        logic [18:0] e;
                        e = exp_q.pop_front();
                        check("chan", int'(bus.chan_o), int'(e[18:16]));
                        check("sample", int'(bus.sample_o), int'(e[15:0]));
                    end
                end
                if (done_o) done_cnt++;
            end
            if (conv_p && !bus.convst_o) conv_falls++;
            if (!bus.convst_o) conv_run++;
            else if (conv_run != 0) begin
                if (conv_run != CONV_LO) conv_bad++;
                conv_run = 0;
            end
            if (rd_p && !bus.rd_o) rd_falls++;
            if (!bus.rd_o) rd_run++;
            else if (rd_run != 0) begin
                if (rd_run != RD_LO) rd_bad++;
                rd_run = 0;
            end
            conv_p = bus.convst_o;
            rd_p = bus.rd_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h0, d0, c0, cb0, r0, rb0, v0, bad;
        reset_i = 1'b1;
        start_i = 1'b0;
        bus.ready_i = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_adc_reset", int'(bus.adc_reset_o), 1);
        check("rst_convst", int'(bus.convst_o), 1);
        check("rst_cs", int'(bus.cs_o), 1);
        check("rst_rd", int'(bus.rd_o), 1);
        check("rst_valid", int'(bus.valid_o), 0);
        check("rst_sample", int'(bus.sample_o), 0);
        check("rst_chan", int'(bus.chan_o), 0);
        check("rst_active", int'(active_o), 1);
        check("rst_done", int'(done_o), 0);
        check("rst_err", int'(err_o), 0);
        @(negedge clk);
        reset_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.adc_reset_o && n < 50);
        check("adc_reset_width", n, RST_CYC);

        // normal frame
        h0 = hs_cnt; d0 = done_cnt; c0 = conv_falls; cb0 = conv_bad;
        r0 = rd_falls; rb0 = rd_bad;
        data_base = 16'h0000;
        push_frame(16'h0000);
        pulse_start();
        n = 0;
        while (bus.cs_o && n < 200) begin tick(); n++; end
        check("cs_fall_seen", int'(bus.cs_o), 0);
        n = 0;
        while (!bus.valid_o && n < 50) begin tick(); n++; end
        check("first_valid_latency", n, RD_LO + RD_HI);
        wait_idle(400);
        repeat (2) tick();
        check("norm_handshakes", hs_cnt - h0, NCHAN);
        check("norm_done", done_cnt - d0, 1);
        check("norm_err", int'(err_o), 0);
        check("norm_convst_pulses", conv_falls - c0, 1);
        check("norm_convst_width_bad", conv_bad - cb0, 0);
        check("norm_rd_strobes", rd_falls - r0, NCHAN);
        check("norm_rd_width_bad", rd_bad - rb0, 0);
        check("norm_sb_drained", exp_q.size(), 0);

        // backpressure
        h0 = hs_cnt; d0 = done_cnt;
        bus.ready_i = 1'b0;
        data_base = 16'h0100;
        push_frame(16'h0100);
        pulse_start();
        n = 0;
        while (!bus.valid_o && n < 200) begin tick(); n++; end
        check("bp_valid_seen", int'(bus.valid_o), 1);
        r0 = rd_falls;
        bad = 0;
        repeat (20) begin
            tick();
            if (!bus.valid_o || bus.sample_o != 16'h0101 || bus.chan_o != 3'd0) bad++;
        end
        check("bp_hold_stable", bad, 0);
        check("bp_one_word_prefetched", rd_falls - r0, 1);
        check("bp_rd_high", int'(bus.rd_o), 1);
        bus.ready_i = 1'b1;
        wait_idle(400);
        repeat (2) tick();
        check("bp_handshakes", hs_cnt - h0, NCHAN);
        check("bp_done", done_cnt - d0, 1);
        check("bp_sb_drained", exp_q.size(), 0);

        // start during WAIT_BUSY_LO is ignored
        h0 = hs_cnt; d0 = done_cnt; c0 = conv_falls;
        data_base = 16'h0200;
        push_frame(16'h0200);
        pulse_start();
        n = 0;
        while (!bus.busy_i && n < 50) begin tick(); n++; end
        repeat (8) tick();
        pulse_start();
        wait_idle(400);
        repeat (60) tick();
        check("ign_handshakes", hs_cnt - h0, NCHAN);
        check("ign_done", done_cnt - d0, 1);
        check("ign_convst_pulses", conv_falls - c0, 1);
        check("ign_idle", int'(active_o), 0);
        check("ign_sb_drained", exp_q.size(), 0);

        // FRSTDATA fault
        h0 = hs_cnt; d0 = done_cnt;
        frst_fault = 1'b1;
        data_base = 16'h0300;
        push_frame(16'h0300);
        pulse_start();
        n = 0;
        while (!bus.valid_o && n < 200) begin tick(); n++; end
        check("frst_err_after_word0", int'(err_o), 2);
        wait_idle(400);
        repeat (2) tick();
        check("frst_handshakes", hs_cnt - h0, NCHAN);
        check("frst_done", done_cnt - d0, 1);
        check("frst_err_final", int'(err_o), 2);
        check("frst_sb_drained", exp_q.size(), 0);
        frst_fault = 1'b0;

        // reset during channel 3 RD_L
        d0 = done_cnt;
        data_base = 16'h0400;
        push_frame(16'h0400);
        r0 = rd_falls;
        pulse_start();
        n = 0;
        while ((rd_falls - r0) < 4 && n < 300) begin tick(); n++; end
        check("mid_reached_ch3", rd_falls - r0, 4);
        check("mid_rd_low", int'(bus.rd_o), 0);
        reset_i = 1'b1;
        #1;
        check("mid_cs", int'(bus.cs_o), 1);
        check("mid_rd", int'(bus.rd_o), 1);
        check("mid_valid", int'(bus.valid_o), 0);
        check("mid_adc_reset", int'(bus.adc_reset_o), 1);
        check("mid_sb_leftover", exp_q.size(), NCHAN - 3);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (bus.adc_reset_o && n < 50);
        check("mid_adc_reset_width", n, RST_CYC);
        repeat (5) tick();
        check("mid_no_done", done_cnt - d0, 0);
        check("mid_err_cleared", int'(err_o), 0);

        // BUSY timeout
        d0 = done_cnt; v0 = valid_seen;
        busy_en = 1'b0;
        pulse_start();
        n = 0;
        while (!bus.convst_o && n < 20) begin tick(); n++; end
        n = 0;
        while (active_o && n < 200) begin tick(); n++; end
        check("to_idle_cycles", n, BUSY_TO + 1);
        check("to_err", int'(err_o), 1);
        repeat (5) tick();
        check("to_no_valid", valid_seen - v0, 0);
        check("to_no_done", done_cnt - d0, 0);
        busy_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
